// File: rtl/bram_burst_reader_if.sv
// Bundle of the command, BRAM read-port and output-stream signals of the burst reader.
// master = the reader itself, slave = its environment (command source, BRAM, consumer).
interface bram_burst_reader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 11
) ();
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [LEN_WIDTH-1:0]  len;
    logic                  busy;
    logic                  done;
    logic                  bram_en;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_dout;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    modport master (
        input  start, base_addr, len, bram_dout, out_ready,
        output busy, done, bram_en, bram_addr, out_valid, out_data
    );

    modport slave (
        output start, base_addr, len, bram_dout, out_ready,
        input  busy, done, bram_en, bram_addr, out_valid, out_data
    );
endinterface

// File: rtl/bram_burst_reader.sv
// Burst reader: fetches len words from base_addr through a registered-read BRAM port and
// streams them out via a 2-entry FIFO. Reads are only issued when a FIFO slot is guaranteed
// for the returning word, so backpressure never drops or duplicates data.
module bram_burst_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 11
) (
    input logic                 clk,
    input logic                 rst_n,
    bram_burst_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  inflight;   // a read was issued last cycle; its data arrives now
    logic [DATA_WIDTH-1:0] fifo_mem0, fifo_mem1;
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            fifo_cnt;
    logic                  pop, push, issue;
    logic [2:0]            credit_use;

    assign pop  = (fifo_cnt != 2'd0) && bus.out_ready;
    assign push = inflight;
    // Slots committed after this edge if nothing new is issued: stored + arriving - leaving.
    assign credit_use = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and read-issue decision
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start)
                    state_nxt = (bus.len == '0) ? DONE : READ;
            end
            READ: begin
                issue = (credit_use < 3'd2);
                if (issue && remaining == LEN_WIDTH'(1))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                // Leave as the final word is popped so done lands the cycle after the pop.
                if (!inflight && (fifo_cnt == 2'd0 || (fifo_cnt == 2'd1 && pop)))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address/length counters and in-flight read tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr  <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= issue;
            if (state == IDLE && bus.start) begin
                cur_addr  <= bus.base_addr;
                remaining <= bus.len;
            end else if (issue) begin
                cur_addr  <= cur_addr + ADDR_WIDTH'(1);
                remaining <= remaining - LEN_WIDTH'(1);
            end
        end
    end

    // Two-entry FIFO; push (returning read data) and pop may coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem0 <= '0;
            fifo_mem1 <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fifo_cnt  <= 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr) fifo_mem1 <= bus.bram_dout;
                else        fifo_mem0 <= bus.bram_dout;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.bram_en   = issue;
    assign bus.bram_addr = cur_addr;
    assign bus.out_valid = (fifo_cnt != 2'd0);
    assign bus.out_data  = rd_ptr ? fifo_mem1 : fifo_mem0;
endmodule
